// File: rtl/pattern_gen.sv
// pattern_gen: run-time sized video test-pattern source feeding the TMDS
// encoder colour inputs. Four patterns (colour bars, grey gradient,
// checkerboard, bouncing box), selected per frame, plus a frame counter.
//
// Ports:
//   i_pixclk    pixel clock, all state on its rising edge
//   i_reset     asynchronous active-high reset
//   i_width     active pixels per line (>=1)
//   i_height    active lines per frame (>=1)
//   i_mode      pattern select, latched at i_newframe
//   i_rd        encoder consumed the current pixel; advance x
//   i_newline   start of the next active line
//   i_newframe  start of a new frame
//   o_pixel     registered {R,G,B} for the current (x,y)
//   o_frame     registered frame counter
module pattern_gen #(
   parameter int unsigned BITS_PER_COLOR = 8,
   parameter int unsigned HW             = 12,
   parameter int unsigned CHECK_LOG2     = 4,
   parameter int unsigned BOX            = 32
) (
   input  logic                          i_pixclk,
   input  logic                          i_reset,
   input  logic [HW-1:0]                 i_width,
   input  logic [HW-1:0]                 i_height,
   input  logic [1:0]                    i_mode,
   input  logic                          i_rd,
   input  logic                          i_newline,
   input  logic                          i_newframe,
   output logic [3*BITS_PER_COLOR-1:0]   o_pixel,
   output logic [7:0]                    o_frame
);

   localparam int unsigned BPC = BITS_PER_COLOR;
   localparam int unsigned PW  = 3 * BPC;
   localparam logic [BPC-1:0] BG_BLUE = BPC'((1 << (BPC - 1)) - (1 << (BPC - 3)));
   localparam logic [HW-1:0]  BOX_W   = HW'(BOX);
   localparam logic [HW:0]    BOX_X   = (HW + 1)'(BOX);

   logic [HW-1:0] x, y, s, bx, by;
   logic [HW-1:0] x_n, y_n, s_n, bx_n, by_n;
   logic [2:0]    b, b_n;
   logic [1:0]    mode_q, mode_n;
   logic          dx, dy, dx_n, dy_n;
   logic [7:0]    frame_n;
   logic [HW-1:0] barw;
   logic          in_box;
   logic [PW-1:0] pix_n;

   // One bounce step of a box coordinate along an axis of length extent.
   // Returns {dir, pos}.
   function automatic logic [HW:0] box_step(input logic [HW-1:0] pos,
                                            input logic          dir,
                                            input logic [HW-1:0] extent);
      logic [HW-1:0] p;
      logic          d;
      p = pos;
      d = dir;
      if (extent <= BOX_W) begin
         p = '0;
      end else if (dir && (pos == extent - BOX_W)) begin
         d = 1'b0;
         p = pos - 1'b1;
      end else if (!dir && (pos == '0)) begin
         d = 1'b1;
         p = HW'(1);
      end else if (dir) begin
         p = pos + 1'b1;
      end else begin
         p = pos - 1'b1;
      end
      return {d, p};
   endfunction

   // Bar width is width/8, never zero so tiny lines still advance.
   always_comb begin
      barw = i_width >> 3;
      if (barw == '0) barw = HW'(1);
   end

   // Next-state counters; newframe beats newline beats rd.
   always_comb begin
      x_n     = x;
      y_n     = y;
      s_n     = s;
      b_n     = b;
      mode_n  = mode_q;
      frame_n = o_frame;
      bx_n    = bx;
      by_n    = by;
      dx_n    = dx;
      dy_n    = dy;
      if (i_newframe) begin
         x_n          = '0;
         y_n          = '0;
         s_n          = '0;
         b_n          = '0;
         mode_n       = i_mode;
         frame_n      = o_frame + 8'd1;
         {dx_n, bx_n} = box_step(bx, dx, i_width);
         {dy_n, by_n} = box_step(by, dy, i_height);
      end else if (i_newline) begin
         x_n = '0;
         s_n = '0;
         b_n = '0;
         y_n = (y < i_height - 1'b1) ? y + 1'b1 : i_height - 1'b1;
      end else if (i_rd) begin
         x_n = (x < i_width - 1'b1) ? x + 1'b1 : i_width - 1'b1;
         if ((s == barw - 1'b1) && (b != 3'd7)) begin
            b_n = b + 3'd1;
            s_n = '0;
         end else begin
            s_n = s + 1'b1;
         end
      end
   end

   // Box hit test in HW+1 bits so bx+BOX cannot wrap.
   always_comb begin
      in_box = ({1'b0, x_n} >= {1'b0, bx_n}) &&
               ({1'b0, x_n} <  ({1'b0, bx_n} + BOX_X)) &&
               ({1'b0, y_n} >= {1'b0, by_n}) &&
               ({1'b0, y_n} <  ({1'b0, by_n} + BOX_X));
   end

   // Pixel colour from the next-state counters so the register tracks (x,y).
   always_comb begin
      pix_n = '1;
      case (mode_n)
         2'd0:    pix_n = {{BPC{~b_n[1]}}, {BPC{~b_n[2]}}, {BPC{~b_n[0]}}};
         2'd1:    pix_n = {3{x_n[BPC-1:0]}};
         2'd2:    pix_n = (x_n[CHECK_LOG2] ^ y_n[CHECK_LOG2]) ? '0 : '1;
         default: pix_n = in_box ? '1 : {{(2 * BPC){1'b0}}, BG_BLUE};
      endcase
   end

   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) begin
         x       <= '0;
         y       <= '0;
         s       <= '0;
         b       <= '0;
         mode_q  <= '0;
         bx      <= '0;
         by      <= '0;
         dx      <= 1'b1;
         dy      <= 1'b1;
         o_frame <= '0;
         o_pixel <= '1;
      end else begin
         x       <= x_n;
         y       <= y_n;
         s       <= s_n;
         b       <= b_n;
         mode_q  <= mode_n;
         bx      <= bx_n;
         by      <= by_n;
         dx      <= dx_n;
         dy      <= dy_n;
         o_frame <= frame_n;
         o_pixel <= pix_n;
      end
   end

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen: directed and random stimulus for pattern_gen, checked
// against a behavioural model (read counts per line, closed-form bounce).
module tb_pattern_gen;

   logic        clk;
   logic        rst;
   logic [11:0] width, height;
   logic [1:0]  mode;
   logic        rd, nl, nf;
   logic [23:0] o_pixel;
   logic [7:0]  o_frame;

   int nassert = 0;
   int nfail   = 0;

   // Model state
   int mx, my, rdc, mode_m, frame_m, nsteps;

   logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   pattern_gen dut (
      .i_pixclk   (clk),
      .i_reset    (rst),
      .i_width    (width),
      .i_height   (height),
      .i_mode     (mode),
      .i_rd       (rd),
      .i_newline  (nl),
      .i_newframe (nf),
      .o_pixel    (o_pixel),
      .o_frame    (o_frame)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Triangle wave: position after n bounce steps over range 0..r.
   function automatic int tri_pos(input int n, input int r);
      int p;
      if (r <= 0) return 0;
      p = n % (2 * r);
      return (p <= r) ? p : 2 * r - p;
   endfunction

   function automatic logic [23:0] exp_pix();
      int w, h, bw, bi, bxv, byv;
      logic [7:0] g;
      w = int'(width);
      h = int'(height);
      case (mode_m)
         0: begin
            bw = w / 8;
            if (bw == 0) bw = 1;
            bi = rdc / bw;
            if (bi > 7) bi = 7;
            return bars[bi];
         end
         1: begin
            g = 8'(mx % 256);
            return {g, g, g};
         end
         2: return ((((mx / 16) ^ (my / 16)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
         default: begin
            bxv = tri_pos(nsteps, w - 32);
            byv = tri_pos(nsteps, h - 32);
            if (mx >= bxv && mx < bxv + 32 && my >= byv && my < byv + 32)
               return 24'hFFFFFF;
            return 24'h000060;
         end
      endcase
   endfunction

   function automatic void model_reset();
      mx = 0; my = 0; rdc = 0; mode_m = 0; frame_m = 0; nsteps = 0;
   endfunction

   function automatic void model_step(input logic r, input logic l, input logic f);
      if (f) begin
         mx = 0; my = 0; rdc = 0;
         mode_m  = int'(mode);
         frame_m = (frame_m + 1) % 256;
         nsteps++;
      end else if (l) begin
         mx = 0; rdc = 0;
         if (my < int'(height) - 1) my++;
      end else if (r) begin
         rdc++;
         if (mx < int'(width) - 1) mx++;
      end
   endfunction

   // One clock with the given strobes; entered and left at a negedge.
   task automatic cyc(input logic r, input logic l, input logic f);
      rd = r; nl = l; nf = f;
      @(posedge clk);
      model_step(r, l, f);
      @(negedge clk);
      rd = 1'b0; nl = 1'b0; nf = 1'b0;
   endtask

   task automatic chk(input string tag);
      logic [23:0] e;
      e = exp_pix();
      nassert++;
      assert (o_pixel === e) else begin
         nfail++;
         $error("FAIL %s pixel: observed %h expected %h", tag, o_pixel, e);
      end
      nassert++;
      assert (o_frame === 8'(frame_m)) else begin
         nfail++;
         $error("FAIL %s frame: observed %0d expected %0d", tag, o_frame, frame_m);
      end
   endtask

   task automatic chk_pix(input string tag, input logic [23:0] e);
      nassert++;
      assert (o_pixel === e) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, o_pixel, e);
      end
   endtask

   task automatic chk_frame(input string tag, input logic [7:0] e);
      nassert++;
      assert (o_frame === e) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, o_frame, e);
      end
   endtask

   // Async reset asserted mid-cycle, checked before any clock edge.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      chk_pix({tag, "_pix"}, 24'hFFFFFF);
      chk_frame({tag, "_frame"}, 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int bxv, byv, r;
      rst = 1'b1; rd = 1'b0; nl = 1'b0; nf = 1'b0;
      width = 12'd640; height = 12'd480; mode = 2'd0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_pix("reset_pix", 24'hFFFFFF);
      chk_frame("reset_frame", 8'd0);
      chk("reset_model");

      // Colour bars across a 640-pixel line
      cyc(0, 0, 1);
      chk("bars_nf");
      for (int k = 1; k <= 640; k++) begin
         cyc(1, 0, 0);
         chk("bars_rd");
         if (k == 79)  chk_pix("bars_79", 24'hFFFFFF);
         if (k == 80)  chk_pix("bars_80", 24'hFFFF00);
         if (k == 560) chk_pix("bars_560", 24'h000000);
      end
      chk_pix("bars_hold", 24'h000000);

      // Gradient, wrap, newline beating rd, mid-frame mode change
      mode = 2'd1;
      cyc(0, 0, 1);
      chk("grad_nf");
      repeat (300) begin
         cyc(1, 0, 0);
         chk("grad_rd");
      end
      chk_pix("grad_300", 24'h2C2C2C);
      cyc(1, 1, 0);
      chk_pix("grad_nl_rd", 24'h000000);
      chk("grad_nl_rd_m");
      mode = 2'd2;
      repeat (20) begin
         cyc(1, 0, 0);
         chk("grad_midmode");
      end
      chk_pix("grad_midmode_20", 24'h141414);

      // Checkerboard
      cyc(0, 0, 1);
      chk("chk_nf");
      for (int k = 1; k <= 16; k++) begin
         cyc(1, 0, 0);
         chk("chk_rd");
         if (k == 15) chk_pix("chk_x15", 24'hFFFFFF);
      end
      chk_pix("chk_x16", 24'h000000);
      cyc(0, 0, 1);
      repeat (16) begin
         cyc(0, 1, 0);
         chk("chk_nl");
      end
      chk_pix("chk_y16", 24'h000000);

      // Reset mid-line, then bouncing box on a 40-wide screen
      repeat (5) cyc(1, 0, 0);
      width = 12'd40;
      do_reset("midline_reset");
      chk("after_reset");
      mode = 2'd3;
      for (int f = 0; f < 18; f++) begin
         cyc(0, 0, 1);
         chk("box_nf");
         bxv = tri_pos(nsteps, 40 - 32);
         byv = tri_pos(nsteps, 480 - 32);
         repeat (byv) begin
            cyc(0, 1, 0);
            chk("box_nl");
         end
         for (int k = 0; k < bxv; k++) begin
            cyc(1, 0, 0);
            chk("box_rd");
            if (k == bxv - 2) chk_pix("box_left_bg", 24'h000060);
         end
         chk_pix("box_corner", 24'hFFFFFF);
         while (mx < 39) begin
            cyc(1, 0, 0);
            chk("box_scan");
            if (mx == bxv + 32) chk_pix("box_right_bg", 24'h000060);
         end
      end

      // Frame counter wrap
      mode = 2'd0;
      width = 12'd640;
      do_reset("wrap_reset");
      repeat (255) begin
         cyc(0, 0, 1);
         chk("wrap_nf");
      end
      chk_frame("frame_255", 8'd255);
      cyc(0, 0, 1);
      chk_frame("frame_wrap", 8'd0);

      // Random strobes, modes and sizes
      width  = 12'($urandom_range(33, 120));
      height = 12'($urandom_range(33, 80));
      do_reset("rand_reset");
      repeat (3000) begin
         mode = 2'($urandom_range(0, 3));
         r = int'($urandom_range(0, 999));
         cyc(1'($urandom_range(0, 3) != 0), r < 30, r < 6);
         chk("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
      $finish;
   end

endmodule
